// File: rtl/rx_pkg.sv
// Shared constants and state type for the serial-to-parallel frame receiver.
package rx_pkg;
  localparam int FRAME_W = 40;
  localparam int HEAD_W = 8;
  localparam int DIV_W = 14;
  localparam int DIV_DEF = 10000;
  localparam logic [HEAD_W-1:0] HEAD_DEF = 8'hA5;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;
endpackage

// File: rtl/ser_bit_timing.sv
// Bit-clock recovery: synchronizes the serial line, re-centres the symbol
// counter on every transition and flags the mid-bit sample point.
module ser_bit_timing
  import rx_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ser_i,
  output logic ser_s,
  output logic sample_en
);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] SAMPLE_PT = DIV_W'(DIV / 2 - 1);

  logic ser_m;
  logic ser_d;
  logic edge_det;
  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_m <= 1'b0;
      ser_s <= 1'b0;
      ser_d <= 1'b0;
    end else begin
      ser_m <= ser_i;
      ser_s <= ser_m;
      ser_d <= ser_s;
    end
  end

  assign edge_det = ser_s ^ ser_d;

  // A transition restarts the bit period so the sample stays centred under jitter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (edge_det) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign sample_en = (div_cnt == SAMPLE_PT) && !edge_det;
endmodule

// File: rtl/ser2para_rx.sv
// Frame receiver: shifts sampled bits MSB-first, hunts for the header,
// then checks every 40th bit for the header while locked.
module ser2para_rx
  import rx_pkg::*;
#(
  parameter int DIV = DIV_DEF,
  parameter logic [HEAD_W-1:0] HEAD = HEAD_DEF,
  parameter logic [1:0] MISS_MAX = 2'd3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ser_i,
  output logic [FRAME_W-1:0] para_o,
  output logic para_valid,
  output logic locked
);
  localparam logic [5:0] FILL_FULL = 6'd40;
  localparam logic [5:0] LAST_BIT = 6'd39;

  logic ser_s;
  logic sample_en;

  state_t state_q, state_n;
  logic [FRAME_W-1:0] sh_q, sh_n, sh_next;
  logic [FRAME_W-1:0] para_q, para_n;
  logic [5:0] fill_q, fill_n;
  logic [5:0] bit_q, bit_n;
  logic [1:0] miss_q, miss_n;
  logic valid_q, valid_n;
  logic locked_q;
  logic hit;

  ser_bit_timing #(.DIV(DIV)) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_i     (ser_i),
    .ser_s     (ser_s),
    .sample_en (sample_en)
  );

  assign sh_next = {sh_q[FRAME_W-2:0], ser_s};
  assign hit = (sh_next[FRAME_W-1:FRAME_W-HEAD_W] == HEAD);

  always_comb begin
    state_n = state_q;
    para_n  = para_q;
    bit_n   = bit_q;
    miss_n  = miss_q;
    valid_n = 1'b0;
    sh_n    = sample_en ? sh_next : sh_q;
    fill_n  = (sample_en && (fill_q != FILL_FULL)) ? fill_q + 6'd1 : fill_q;
    case (state_q)
      HUNT: begin
        if (sample_en && (fill_q >= LAST_BIT) && hit) begin
          para_n  = sh_next;
          valid_n = 1'b1;
          bit_n   = '0;
          miss_n  = '0;
          state_n = LOCKED;
        end
      end
      LOCKED: begin
        if (sample_en) begin
          if (bit_q == LAST_BIT) begin
            bit_n = '0;
            if (hit) begin
              para_n  = sh_next;
              valid_n = 1'b1;
              miss_n  = '0;
            end else begin
              miss_n = miss_q + 2'd1;
              // fill_cnt is already saturated, so hunting resumes on the next sample
              if ((miss_q + 2'd1) == MISS_MAX) state_n = HUNT;
            end
          end else begin
            bit_n = bit_q + 6'd1;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      sh_q     <= '0;
      para_q   <= '0;
      fill_q   <= '0;
      bit_q    <= '0;
      miss_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      sh_q     <= sh_n;
      para_q   <= para_n;
      fill_q   <= fill_n;
      bit_q    <= bit_n;
      miss_q   <= miss_n;
      valid_q  <= valid_n;
      locked_q <= (state_n == LOCKED);
    end
  end

  assign para_o = para_q;
  assign para_valid = valid_q;
  assign locked = locked_q;
endmodule

// File: tb/tb_ser2para_rx.sv
// Bench for ser2para_rx: serializes frames at DIV=16 with optional jitter and
// scores every valid frame against a bit-stream framing model.
module tb_ser2para_rx;
  localparam int DIV = 16;
  localparam logic [7:0] HEAD = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ser_i = 1'b0;
  logic [39:0] para_o;
  logic para_valid;
  logic locked;

  ser2para_rx #(.DIV(DIV), .HEAD(HEAD), .MISS_MAX(2'd3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_i      (ser_i),
    .para_o     (para_o),
    .para_valid (para_valid),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic [39:0] exp_q[$];

  // Reference model state: received bit history and frame-level lock view
  bit hist[$];
  bit m_locked = 1'b0;
  int m_bits = 0;
  int m_miss = 0;
  logic [39:0] m_last = '0;
  int valid_exp = 0;
  int valid_seen = 0;

  bit check_lock = 1'b0;
  bit check_period = 1'b0;
  int jit_max = 0;
  int j_cur = 0;
  int cyc = 0;
  int last_valid_cyc = -1;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [39:0] window();
    logic [39:0] w = '0;
    foreach (hist[i]) w = {w[38:0], hist[i]};
    return w;
  endfunction

  task automatic accept(input logic [39:0] w);
    exp_q.push_back(w);
    m_last = w;
    valid_exp++;
  endtask

  // Apply the framing rules to one received bit.
  task automatic model_bit(input bit b);
    logic [39:0] w;
    hist.push_back(b);
    if (hist.size() > 40) void'(hist.pop_front());
    w = window();
    if (!m_locked) begin
      if (hist.size() == 40 && w[39:32] == HEAD) begin
        accept(w);
        m_locked = 1'b1;
        m_bits = 0;
        m_miss = 0;
      end
    end else begin
      m_bits++;
      if (m_bits == 40) begin
        m_bits = 0;
        if (w[39:32] == HEAD) begin
          accept(w);
          m_miss = 0;
        end else begin
          m_miss++;
          if (m_miss == 3) m_locked = 1'b0;
        end
      end
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    hist.delete();
    m_locked = 1'b0;
    m_bits = 0;
    m_miss = 0;
    last_valid_cyc = -1;
    j_cur = 0;
  endtask

  task automatic send_bit(input bit b);
    int j_next;
    j_next = (jit_max > 0) ? int'($urandom_range(0, 2 * jit_max)) - jit_max : 0;
    model_bit(b);
    ser_i = b;
    repeat (DIV + j_next - j_cur) @(negedge clk);
    j_cur = j_next;
    if (check_lock) check("locked", {39'd0, locked}, {39'd0, m_locked});
  endtask

  task automatic send_frame(input logic [39:0] f, input int from);
    for (int i = from; i >= 0; i--) send_bit(f[i]);
  endtask

  function automatic logic [39:0] good_frame();
    return {HEAD, 32'($urandom)};
  endfunction

  function automatic logic [39:0] bad_frame();
    logic [7:0] h;
    h = 8'($urandom_range(0, 255));
    if (h == HEAD) h = 8'h5A;
    return {h, 32'($urandom)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    repeat (4) @(negedge clk);
    check("reset_para", para_o, 40'd0);
    check("reset_flags", {38'd0, para_valid, locked}, 40'd0);
    rst_n = 1'b1;
  endtask

  // Monitor: every valid strobe consumes one expected frame.
  always @(negedge clk) begin
    if (rst_n && para_valid) begin
      valid_seen++;
      check("valid_single", {39'd0, prev_valid}, 40'd0);
      check("locked_at_valid", {39'd0, locked}, 40'd1);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got %h, expected no frame", para_o);
      end else begin
        check("para_o", para_o, exp_q.pop_front());
      end
      if (check_period && last_valid_cyc >= 0)
        check("valid_period", 40'(cyc - last_valid_cyc), 40'd640);
      last_valid_cyc = cyc;
    end
    prev_valid <= rst_n && para_valid;
  end

  initial begin
    logic [39:0] fixed;
    logic [39:0] f;
    fixed = 40'hA5_0123_4567;

    // Reset held while the line toggles
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      ser_i = 1'($urandom_range(0, 1));
      if (i % 4 == 3) check("held_reset", {para_o[37:0], para_valid, locked}, 40'd0);
    end

    // Continuous fixed frame, exact 640-cycle spacing
    do_reset();
    check_lock = 1'b1;
    check_period = 1'b1;
    for (int k = 0; k < 4; k++) send_frame(fixed, 39);
    check_period = 1'b0;

    // Stream joined mid-frame at bit 17
    do_reset();
    f = good_frame();
    send_frame(f, 17);
    for (int k = 0; k < 3; k++) send_frame(good_frame(), 39);

    // Two bad headers keep lock and hold para_o
    send_frame({8'h00, 32'($urandom)}, 39);
    send_frame({8'h00, 32'($urandom)}, 39);
    check("hold_para", para_o, m_last);
    for (int k = 0; k < 2; k++) send_frame(good_frame(), 39);

    // Three bad headers drop lock, then relock
    for (int k = 0; k < 3; k++) send_frame(bad_frame(), 39);
    check("lock_dropped", {39'd0, locked}, {39'd0, m_locked});
    for (int k = 0; k < 3; k++) send_frame(good_frame(), 39);

    // Jittered bit boundaries
    check_lock = 1'b0;
    do_reset();
    jit_max = 3;
    for (int k = 0; k < 6; k++) send_frame(good_frame(), 39);
    jit_max = 0;

    // Reset pulsed mid-frame, asynchronously
    do_reset();
    check_lock = 1'b1;
    for (int k = 0; k < 2; k++) send_frame(good_frame(), 39);
    send_frame(good_frame(), 39 - 20 + 20);
    f = good_frame();
    for (int i = 39; i >= 20; i--) send_bit(f[i]);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_para", para_o, 40'd0);
    check("async_reset_flags", {38'd0, para_valid, locked}, 40'd0);
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) send_frame(good_frame(), 39);

    repeat (2 * DIV) @(negedge clk);
    check("valid_count", 40'(valid_seen), 40'(valid_exp));
    check("queue_drained", 40'(exp_q.size()), 40'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
